// File: rtl/div_unit.sv
// div_unit: multicycle signed divider, restoring shift-subtract, one quotient
// bit per clock. Semantics match the MIPS div instruction: the quotient
// truncates toward zero and the remainder takes the sign of the dividend.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-low
//   start    - division request, sampled only in IDLE
//   dividend - signed dividend, sampled on the accepting edge
//   divisor  - signed divisor, sampled on the accepting edge
//   hi_out   - remainder of the last completed division
//   lo_out   - quotient of the last completed division
//   busy     - division in flight (RUN or FIX)
//   done     - one-cycle pulse, results valid from this cycle on
//   div_zero - one-cycle pulse, the request had divisor == 0
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | WIDTH shift-subtract iterations on magnitudes
// FIX   | apply signs, write results, pulse done next cycle
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     pr_q;      // {remainder, dividend bits shifting out / quotient bits shifting in}
  logic [WIDTH-1:0]       dvs_q;
  logic [CW-1:0]          cnt_q;
  logic                   qneg_q, rneg_q;
  logic [WIDTH-1:0]       hi_q, lo_q;
  logic                   done_q, dz_q;

  logic                   accept, dz_req;
  logic [2*WIDTH:0]       shifted;
  logic [WIDTH:0]         top, diff;
  logic                   ge;
  logic [2*WIDTH-1:0]     pr_step;
  logic [WIDTH-1:0]       quo, rem;

  // Unsigned magnitude: the most negative value maps onto itself as an
  // unsigned number, which is what lets MIN / -1 come out as MIN with rem 0.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign accept = (state_q == IDLE) && start && (divisor != '0);
  assign dz_req = (state_q == IDLE) && start && (divisor == '0);

  // One restoring step. Remainder is always < divisor before the shift, so
  // the difference fits back into WIDTH bits.
  always_comb begin
    shifted = {pr_q, 1'b0};
    top     = shifted[2*WIDTH:WIDTH];
    diff    = top - {1'b0, dvs_q};
    ge      = (top >= {1'b0, dvs_q});
    pr_step = ge ? {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1}
                 : shifted[2*WIDTH-1:0];
  end

  assign rem = pr_q[2*WIDTH-1:WIDTH];
  assign quo = pr_q[WIDTH-1:0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pr_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      dz_q   <= dz_req;
      case (state_q)
        IDLE: begin
          if (accept) begin
            pr_q   <= {{WIDTH{1'b0}}, mag(dividend)};
            dvs_q  <= mag(divisor);
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
            cnt_q  <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          pr_q <= pr_step;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          lo_q <= qneg_q ? (~quo + 1'b1) : quo;
          hi_q <= rneg_q ? (~rem + 1'b1) : rem;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi_out   = hi_q;
    lo_out   = lo_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected {hi, lo} pairs are
// queued when a request is driven and compared whenever done pulses.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend, divisor;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;

  div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {remainder, quotient}, MIPS div semantics.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Scoreboard consumer and pulse-exclusivity monitor
  always @(negedge clock) begin
    logic [63:0] e;
    if (reset && (done || div_zero))
      check("done_dz_excl", {63'b0, done & div_zero}, 64'd0);
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi_out", {32'b0, hi_out}, {32'b0, e[63:32]});
        check("lo_out", {32'b0, lo_out}, {32'b0, e[31:0]});
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen, so a
  // following call lands its request on the earliest accepting edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat, bcnt;
    bit got;
    e = model(a, b);
    exp_q.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    bcnt = int'(busy);
    lat  = 0;
    got  = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clock);
      if (i == 16) begin
        check("hold_hi", {32'b0, hi_out}, {32'b0, last_hi});
        check("hold_lo", {32'b0, lo_out}, {32'b0, last_lo});
      end
      if (done) begin
        got = 1;
        lat = i;
      end else begin
        bcnt += int'(busy);
      end
    end
    check("latency", 64'(lat), 64'd33);
    check("busy_cycles", 64'(bcnt), 64'd33);
    check("busy_after_done", {63'b0, busy}, 64'd0);
    last_hi = e[63:32];
    last_lo = e[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit got;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_hi  = '0;
    last_lo  = '0;
    #12;
    check("rst_hi", {32'b0, hi_out}, 64'd0);
    check("rst_lo", {32'b0, lo_out}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dz", {63'b0, div_zero}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Back-to-back directed cases
    do_div(32'd7, 32'd2);
    do_div(32'hFFFF_FFF9, 32'd2);
    do_div(32'd7, 32'hFFFF_FFFE);
    do_div(32'h8000_0000, 32'hFFFF_FFFF);
    do_div(32'd5, 32'd7);
    do_div(32'd7, 32'd2);

    // Divide by zero keeps previous results
    dividend = 32'd9;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("dz_pulse", {63'b0, div_zero}, 64'd1);
    check("dz_busy", {63'b0, busy}, 64'd0);
    @(negedge clock);
    check("dz_one_cycle", {63'b0, div_zero}, 64'd0);
    repeat (40) @(negedge clock);
    check("dz_hi_kept", {32'b0, hi_out}, 64'd1);
    check("dz_lo_kept", {32'b0, lo_out}, 64'd3);

    // Second start during RUN is ignored
    exp_q.push_back(model(32'd100, 32'd7));
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    dividend = 32'd1;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (done) got = 1;
    end
    check("ignore_done_seen", {63'b0, got}, 64'd1);
    repeat (40) @(negedge clock);
    check("sb_empty_ignore", 64'(exp_q.size()), 64'd0);
    last_hi = 32'd2;
    last_lo = 32'd14;

    // Reset in the middle of a division
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_hi", {32'b0, hi_out}, 64'd0);
    check("mid_rst_lo", {32'b0, lo_out}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_done", {63'b0, done}, 64'd0);
    @(negedge clock);
    reset   = 1'b1;
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clock);
    do_div(32'd100, 32'd7);

    // Boundary and random operands
    do_div(32'd0, 32'd3);
    do_div(32'h8000_0000, 32'd1);
    do_div(32'h7FFF_FFFF, 32'h8000_0000);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k < 3) ? $urandom_range(1, 20) : $urandom;
      if (k == 1) rb = -rb;
      if (rb == 0) rb = 32'd1;
      do_div(ra, rb);
    end

    repeat (2) @(negedge clock);
    check("sb_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
